baud_tick_generator: RTL and testbench
======================================

Name: baud_tick_generator

Overview:
Parametrised successor to the team's fixed-table baud square-wave generator. It produces single-cycle oversample ticks, mid-bit ticks and bit ticks for the UART TX/RX engines, plus a compatible square-wave baud output. The divisor comes either from a 4-entry preset table (2400/4800/9600/19200) or from a runtime-loaded custom divisor. A synchronous restart lets the RX engine align bit timing to a start-bit edge.

Parameters:
FREQ, 50e6, system clock frequency in Hz
OVERSAMPLE, 16, os_ticks per bit; even, range 4..32
DIV_W, 16, width of the integer divisor and the oversample counter
FRAC_W, 4, fractional divisor bits; used only when BAUD_FRAC_EN is defined

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
en  input  1  count enable; low holds all counters
restart  input  1  synchronous clear of the oversample and bit counters
baud_sel  input  2  preset select: 00=2400, 01=4800, 10=9600, 11=19200
cfg_mode  input  1  0=preset divisor, 1=custom divisor register
cfg_we  input  1  load strobe for cfg_div
cfg_div  input  DIV_W+FRAC_W  custom divisor; integer part in upper DIV_W bits, fraction in lower FRAC_W bits
os_tick  output  1  one-cycle pulse every divisor clocks
mid_tick  output  1  one-cycle pulse on the (OVERSAMPLE/2)-th os_tick of each bit
bit_tick  output  1  one-cycle pulse on the OVERSAMPLE-th os_tick of each bit
baud_out  output  1  square wave, period = one bit; toggles on mid_tick and on bit_tick

Behaviour:
- Reset (arst_n low, asynchronous): os_cnt=0, bit_cnt=0, frac_acc=0, custom divisor register=2 (integer part); os_tick=mid_tick=bit_tick=0, baud_out=0.
- Preset divisors are localparams: DIV_n = (FREQ + B*OVERSAMPLE/2) / (B*OVERSAMPLE), i.e. rounded to nearest. At 50e6/16x: 2400→1302, 4800→651, 9600→326, 19200→163.
- Effective divisor D: preset from baud_sel when cfg_mode=0, else the custom register. Any D<2 is clamped to 2.
- cfg_we high at a clock edge loads cfg_div into the custom register at that edge. It is accepted regardless of en.
- Divisor change: if D differs from D of the previous cycle (baud_sel, cfg_mode or register change), os_cnt and bit_cnt clear on the next edge, exactly as for restart. No tick is emitted on that edge.
- Oversample counter: with en=1, os_cnt increments each clock. When os_cnt==D-1, it wraps to 0 and os_tick is registered high for the following cycle. Period = D clocks; the first os_tick goes high D clocks after a restart edge.
- Bit counter: range 0..OVERSAMPLE-1. It advances on each os wrap.
  - mid_tick fires with the os_tick that takes bit_cnt from OVERSAMPLE/2-1 to OVERSAMPLE/2.
  - bit_tick fires with the os_tick that takes bit_cnt from OVERSAMPLE-1 to 0.
  - All ticks are registered and coincident with their os_tick.
- baud_out toggles on the same edge that raises mid_tick or bit_tick.
- restart high at an edge: os_cnt=0, bit_cnt=0, frac_acc=0; all tick outputs 0 next cycle; baud_out forced to 0. restart has priority over en and over wrap.
- en low: counters and baud_out hold; tick outputs 0. Counting resumes from the held value.
- Simultaneous restart and cfg_we: both take effect and timing starts with the new D.
- Reset mid-operation aborts immediately, with no glitch pulse after release.

Optional Feature:
BAUD_FRAC_EN
- Defined:
  - On each os wrap, frac_acc (FRAC_W bits) += fractional part of D.
  - On carry-out, the next os period is D+1 clocks.
  - Presets carry fractions: round(16*FREQ/(B*OVERSAMPLE)) split into integer and FRAC_W parts; 9600@50e6 → 325 + 8/16.
- Not defined:
  - The fractional bits of cfg_div are ignored and frac_acc does not exist.
  - Presets are integer-rounded as above.
  - The port list is unchanged.

Test Plan:
- Reset release, en=1, baud_sel=10, cfg_mode=0 → os_tick every 326 clk; mid_tick at clk 2608; bit_tick every 5216 clk; baud_out toggles at 2608 and 5216.
- baud_sel 10→11 mid-bit → counters clear; first os_tick 163 clk later; bit_tick period 2608.
- cfg_mode=1, cfg_we with cfg_div integer=10, restart pulse → os_tick at +10, +20; bit_tick at +160; restart at clk 75 → next os_tick at 85, baud_out=0.
- cfg_div integer 0 and 1 → behaves as D=2, os_tick every 2 clk; en low for 50 clk mid-period → no ticks; period resumes from held count.
- arst_n pulsed low mid-bit → all outputs 0 asynchronously; after release, first os_tick D clk later; custom register back to 2.
- With BAUD_FRAC_EN, custom 10+8/16 → os periods alternate 10,11; 16 os_ticks span 168 clk; same config without the macro → 160 clk.

Source files
------------

// File: rtl/baud_tick_generator.sv
// Baud timing for the UART engines: oversample, mid-bit and bit ticks plus a square-wave baud output.
// Define BAUD_FRAC_EN to enable fractional divisors (FRAC_W bits) through a phase accumulator.
module baud_tick_generator #(
    parameter longint FREQ       = 50_000_000,
    parameter int     OVERSAMPLE = 16,
    parameter int     DIV_W      = 16,
    parameter int     FRAC_W     = 4
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    en,
    input  logic                    restart,
    input  logic [1:0]              baud_sel,
    input  logic                    cfg_mode,
    input  logic                    cfg_we,
    input  logic [DIV_W+FRAC_W-1:0] cfg_div,
    output logic                    os_tick,
    output logic                    mid_tick,
    output logic                    bit_tick,
    output logic                    baud_out
);
    localparam int DW  = DIV_W + FRAC_W;
    localparam int BCW = $clog2(OVERSAMPLE);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_MID  = BCW'(OVERSAMPLE / 2 - 1);
    localparam logic [DW-1:0]  D_MIN    = DW'(2) << FRAC_W;

    // Divisors are held as fixed point {integer, fraction} so both builds share one datapath.
    function automatic logic [DW-1:0] preset_div(input int sel);
        longint bo;
        longint full;
        bo = (longint'(2400) << sel) * OVERSAMPLE;
`ifdef BAUD_FRAC_EN
        full = ((FREQ << FRAC_W) + bo / 2) / bo;
`else
        full = ((FREQ + bo / 2) / bo) << FRAC_W;
`endif
        return DW'(full);
    endfunction

    localparam logic [DW-1:0] PRE0 = preset_div(0);
    localparam logic [DW-1:0] PRE1 = preset_div(1);
    localparam logic [DW-1:0] PRE2 = preset_div(2);
    localparam logic [DW-1:0] PRE3 = preset_div(3);

    function automatic logic [DW-1:0] eff_div(input logic mode, input logic [1:0] sel,
                                              input logic [DW-1:0] rv);
        logic [DW-1:0] d;
        d = rv;
        if (!mode) begin
            case (sel)
                2'd0:    d = PRE0;
                2'd1:    d = PRE1;
                2'd2:    d = PRE2;
                default: d = PRE3;
            endcase
        end
`ifndef BAUD_FRAC_EN
        d[FRAC_W-1:0] = '0;
`endif
        if (d[DW-1:FRAC_W] < DIV_W'(2)) d = D_MIN;
        return d;
    endfunction

    logic [DW-1:0]    div_q, div_d;
    logic [DW-1:0]    prev_d_q, prev_d_d;
    logic             prev_vld_q;
    logic [DIV_W-1:0] os_cnt_q, os_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             os_tick_q, os_tick_d, mid_q, mid_d, bit_q, bit_d, baud_q, baud_d;
    logic [DW-1:0]    d_cur, d_new;
    logic [DIV_W-1:0] os_lim;
    logic             clr, wrap, carry;

    assign div_d = cfg_we ? cfg_div : div_q;
    assign d_cur = eff_div(cfg_mode, baud_sel, div_q);
    assign d_new = eff_div(cfg_mode, baud_sel, div_d);
    assign clr   = restart || (prev_vld_q && (d_cur != prev_d_q));
    // A restart already realigns timing, so it absorbs a divisor load on the same edge.
    assign prev_d_d = restart ? d_new : d_cur;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;
    assign acc_sum = {1'b0, acc_q} + {1'b0, d_cur[FRAC_W-1:0]};
    assign carry   = acc_sum[FRAC_W];

    always_comb begin
        acc_d = acc_q;
        if (clr)              acc_d = '0;
        else if (en && wrap)  acc_d = acc_sum[FRAC_W-1:0];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) acc_q <= '0;
        else         acc_q <= acc_d;
    end
`else
    assign carry = 1'b0;
`endif

    assign os_lim = d_cur[DW-1:FRAC_W] - DIV_W'(1) + DIV_W'(carry);
    assign wrap   = (os_cnt_q == os_lim);

    always_comb begin
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        os_tick_d = 1'b0;
        mid_d     = 1'b0;
        bit_d     = 1'b0;
        if (clr) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            baud_d    = 1'b0;
        end else if (en) begin
            if (wrap) begin
                os_cnt_d  = '0;
                os_tick_d = 1'b1;
                mid_d     = (bit_cnt_q == BIT_MID);
                bit_d     = (bit_cnt_q == BIT_LAST);
                bit_cnt_d = bit_d ? '0 : bit_cnt_q + 1'b1;
                if (mid_d || bit_d) baud_d = ~baud_q;
            end else begin
                os_cnt_d = os_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_q      <= D_MIN;
            prev_d_q   <= '0;
            prev_vld_q <= 1'b0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            os_tick_q  <= 1'b0;
            mid_q      <= 1'b0;
            bit_q      <= 1'b0;
            baud_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            prev_d_q   <= prev_d_d;
            prev_vld_q <= 1'b1;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            os_tick_q  <= os_tick_d;
            mid_q      <= mid_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
    assign baud_out = baud_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Bench for baud_tick_generator: directed scenarios plus random traffic, checked every cycle
// against a time-based reference model (tick k of a run lands at k*Dint + floor(k*frac/2^FRAC_W)).
module tb_baud_tick_generator;
    localparam longint FREQ   = 50_000_000;
    localparam int     OS     = 16;
    localparam int     DIV_W  = 16;
    localparam int     FRAC_W = 4;
    localparam int     DW     = DIV_W + FRAC_W;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic          clk = 1'b0, arst_n = 1'b0, en = 1'b0, restart = 1'b0;
    logic          cfg_mode = 1'b0, cfg_we = 1'b0;
    logic [1:0]    baud_sel = 2'd0;
    logic [DW-1:0] cfg_div = '0;
    logic          os_tick, mid_tick, bit_tick, baud_out;

    int checks = 0;
    int errors = 0;

    baud_tick_generator #(.FREQ(FREQ), .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .arst_n(arst_n), .en(en), .restart(restart), .baud_sel(baud_sel),
        .cfg_mode(cfg_mode), .cfg_we(cfg_we), .cfg_div(cfg_div),
        .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick), .baud_out(baud_out)
    );

    always #5 clk = ~clk;

    // Reference model state: enabled clocks and ticks since the last alignment point.
    longint m_reg, m_prev, m_n, m_k, m_next, m_dint, m_frac;
    bit     m_vld;
    bit     e_os, e_mid, e_bit, e_baud;

    function automatic longint m_eff(bit mode, logic [1:0] sel, longint rv);
        longint b, d;
        if (mode) d = FRAC ? rv : ((rv >> FRAC_W) << FRAC_W);
        else begin
            b = 2400 * (longint'(1) << sel) * OS;
            d = FRAC ? ((FREQ << FRAC_W) + b / 2) / b : ((FREQ + b / 2) / b) << FRAC_W;
        end
        if ((d >> FRAC_W) < 2) d = longint'(2) << FRAC_W;
        return d;
    endfunction

    function automatic longint t_of(longint k);
        return k * m_dint + ((k * m_frac) >> FRAC_W);
    endfunction

    task automatic m_start(longint d);
        m_dint = d >> FRAC_W;
        m_frac = d % (longint'(1) << FRAC_W);
        m_n = 0;
        m_k = 0;
        m_next = t_of(1);
    endtask

    task automatic m_reset();
        m_reg = longint'(2) << FRAC_W;
        m_vld = 1'b0;
        e_os = 0; e_mid = 0; e_bit = 0; e_baud = 0;
    endtask

    task automatic m_edge();
        longint dc, dn, rn;
        rn = cfg_we ? longint'(cfg_div) : m_reg;
        dc = m_eff(cfg_mode, baud_sel, m_reg);
        dn = m_eff(cfg_mode, baud_sel, rn);
        if (!m_vld) m_start(dc);
        e_os = 0; e_mid = 0; e_bit = 0;
        if (restart || (m_vld && dc != m_prev)) begin
            m_start(restart ? dn : dc);
            e_baud = 0;
        end else if (en) begin
            m_n++;
            if (m_n == m_next) begin
                m_k++;
                m_next = t_of(m_k + 1);
                e_os  = 1;
                e_mid = (m_k % OS) == OS / 2;
                e_bit = (m_k % OS) == 0;
            end
            e_baud = ((m_k / (OS / 2)) % 2) == 1;
        end
        m_prev = restart ? dn : dc;
        m_reg  = rn;
        m_vld  = 1'b1;
    endtask

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t obs=%0b exp=%0b", tag, $time, obs, exp);
        end
    endtask

    task automatic chki(string tag, longint obs, longint exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("os_tick", os_tick, e_os);
        chk("mid_tick", mid_tick, e_mid);
        chk("bit_tick", bit_tick, e_bit);
        chk("baud_out", baud_out, e_baud);
    endtask

    task automatic step(int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            m_edge();
            #1;
            cmp_all();
        end
    endtask

    task automatic load(int ival, int fval, bit rst);
        cfg_div = {DIV_W'(ival), FRAC_W'(fval)};
        cfg_we  = 1'b1;
        restart = rst;
        step(1);
        cfg_we  = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        longint first_os, first_mid, first_bit, span, d9600;
        int     nos;
        m_reset();

        // Reset state, with inputs already asking to count.
        en = 1'b1; baud_sel = 2'd2; cfg_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_os", os_tick, 1'b0);
        chk("rst_mid", mid_tick, 1'b0);
        chk("rst_bit", bit_tick, 1'b0);
        chk("rst_baud", baud_out, 1'b0);
        arst_n = 1'b1;

        // 9600 preset from reset release: first os, mid and bit tick positions.
        d9600 = m_eff(1'b0, 2'd2, 0);
        first_os = -1; first_mid = -1; first_bit = -1;
        for (int c = 1; c <= 6000 && first_bit < 0; c++) begin
            step(1);
            if (os_tick && first_os < 0)   first_os = c;
            if (mid_tick && first_mid < 0) first_mid = c;
            if (bit_tick && first_bit < 0) first_bit = c;
        end
        m_dint = d9600 >> FRAC_W;
        m_frac = d9600 % (longint'(1) << FRAC_W);
        chki("first_os_9600", first_os, t_of(1));
        chki("first_mid_9600", first_mid, t_of(OS / 2));
        chki("first_bit_9600", first_bit, t_of(OS));
        step(3000);

        // Preset change mid-bit clears timing.
        baud_sel = 2'd3;
        step(2700);

        // Custom divisor 10 loaded together with restart, then a restart at clk 75.
        cfg_mode = 1'b1;
        load(10, 0, 1'b1);
        step(74);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        first_os = -1;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (os_tick && first_os < 0) first_os = c;
        end
        chki("os_after_restart", first_os, 10);

        // Divisor clamps: 0 and 1 behave as 2.
        load(0, 0, 1'b0);
        step(20);
        load(1, $urandom_range(0, 15), 1'b0);
        step(20);

        // en low mid-period holds the count.
        load(10, 0, 1'b0);
        step(5);
        en = 1'b0;
        step(50);
        en = 1'b1;
        step(40);

        // Async reset mid-bit with baud_out high, then custom register back to 2.
        load(10, 0, 1'b1);
        step(95);
        chk("pre_rst_baud", baud_out, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_os", os_tick, 1'b0);
        chk("arst_mid", mid_tick, 1'b0);
        chk("arst_bit", bit_tick, 1'b0);
        chk("arst_baud", baud_out, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_baud", baud_out, 1'b0);
        arst_n = 1'b1;
        step(40);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 99) == 0);
            cfg_we  = ($urandom_range(0, 99) == 0);
            cfg_div = {DIV_W'($urandom_range(0, 24)), FRAC_W'($urandom_range(0, 15))};
            if ($urandom_range(0, 299) == 0) cfg_mode = ~cfg_mode;
            if ($urandom_range(0, 199) == 0) baud_sel = 2'($urandom_range(0, 3));
            step(1);
        end
        en = 1'b1; restart = 1'b0; cfg_we = 1'b0; cfg_mode = 1'b1;

        // Fractional divisor 10 + 8/16: span of 16 os_ticks after restart.
        load(10, 8, 1'b1);
        nos = 0;
        span = -1;
        for (int c = 1; c <= 400 && span < 0; c++) begin
            step(1);
            if (os_tick) nos++;
            if (nos == 16) span = c;
        end
        chki("frac_span16", span, FRAC ? 168 : 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
